store_trace_checker: RTL and testbench

Parametrised, synthesizable successor to the chip-level answer checker. Snoops the data-cache write port of the CHIP under test and compares every store that lands in a configurable answer window against a loadable expected-value table. Reports error count, cycle duration, completion and timeout. Sits beside `CHIP` in the final bench and can also be instantiated on-chip as a self-test monitor.

---
 rtl/stc_pkg.sv | 25 ++
 rtl/sat_counter.sv | 31 +++
 rtl/store_trace_checker.sv | 115 +++++++++++
 tb/tb_store_trace_checker.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/stc_pkg.sv
// rtl/stc_pkg.sv - shared types and answer-window decode for store_trace_checker
package stc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic        hit;
      logic [63:0] offset;
   } win_t;

   // Evaluated at 64 bits so ANS_BASE+DEPTH cannot wrap at the top of the address space.
   function automatic win_t window_check(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input logic [63:0] depth);
      win_t r;
      r.offset = addr - base;
      r.hit    = (addr >= base) && (r.offset < depth);
      return r;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter with enable and sync clear that sticks at all-ones
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (en_i && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/store_trace_checker.sv
// rtl/store_trace_checker.sv - snoops dcache stores and scores the answer window against an expected table
import stc_pkg::*;

module store_trace_checker #(
   parameter int              ADDR_W   = 30,
   parameter int              DATA_W   = 32,
   parameter int              DEPTH    = 16,
   parameter logic [ADDR_W-1:0] ANS_BASE = 30'h0000_0040,
   parameter int              DUR_W    = 16,
   parameter int              ERR_W    = 8,
   parameter int              TIMEOUT  = 10000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     exp_we,
   input  logic [$clog2(DEPTH)-1:0] exp_idx,
   input  logic [DATA_W-1:0]        exp_data,
   input  logic [ADDR_W-1:0]        addr,
   input  logic [DATA_W-1:0]        data,
   input  logic                     wen,
   output logic [ERR_W-1:0]         error_num,
   output logic [DUR_W-1:0]         duration,
   output logic                     finish,
   output logic                     timeout,
   output logic [1:0]               curstate
);

   localparam int IDX_W = $clog2(DEPTH);

   state_e              state_q, state_d;
   logic [DEPTH-1:0]    seen_q, seen_d;
   logic                finish_q, finish_d;
   logic                timeout_q, timeout_d;
   logic [DATA_W-1:0]   exp_q [DEPTH];

   win_t                win;
   logic                hit;
   logic [IDX_W-1:0]    idx;
   logic [DEPTH-1:0]    hit_mask;
   logic                active;
   logic                err_en;
   logic                timeout_hit;

   assign win      = window_check(64'(addr), 64'(ANS_BASE), 64'(DEPTH));
   assign idx      = win.offset[IDX_W-1:0];
   assign hit      = wen && win.hit && (win.offset[63:IDX_W] == '0);
   assign hit_mask = {{(DEPTH-1){1'b0}}, 1'b1} << idx;
   assign active   = (state_q != DONE);

   // The table read here is the pre-edge value, so a same-cycle load never affects this compare.
   assign err_en      = active && hit && (data != exp_q[idx]);
   assign timeout_hit = (duration == DUR_W'(TIMEOUT - 1));

   always_comb begin
      state_d   = state_q;
      seen_d    = seen_q;
      finish_d  = finish_q;
      timeout_d = timeout_q;
      if (active) begin
         if (hit) begin
            seen_d = seen_q | hit_mask;
         end
         if (hit && (&seen_d)) begin
            state_d  = DONE;
            finish_d = 1'b1;
         end else if (timeout_hit) begin
            state_d   = DONE;
            finish_d  = 1'b1;
            timeout_d = 1'b1;
         end else if (hit) begin
            state_d = RUN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         seen_q    <= '0;
         finish_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         seen_q    <= seen_d;
         finish_q  <= finish_d;
         timeout_q <= timeout_d;
      end
   end

   // Table survives reset so a bench can load it once and rerun the program.
   always_ff @(posedge clk) begin
      if (rst_n && exp_we && (state_q == IDLE)) begin
         exp_q[exp_idx] <= exp_data;
      end
   end

   sat_counter #(.W(ERR_W)) u_err_cnt (
      .clk_i   (clk),
      .clr_i   (!rst_n),
      .en_i    (err_en),
      .count_o (error_num)
   );

   sat_counter #(.W(DUR_W)) u_dur_cnt (
      .clk_i   (clk),
      .clr_i   (!rst_n),
      .en_i    (active),
      .count_o (duration)
   );

   assign finish   = finish_q;
   assign timeout  = timeout_q;
   assign curstate = state_q;

endmodule

// File: tb/tb_store_trace_checker.sv
// tb/tb_store_trace_checker.sv - directed and random stimulus scored against a behavioural model
module tb_store_trace_checker;

   localparam int BASE    = 'h40;
   localparam int DEPTH   = 4;
   localparam int TMO     = 50;
   localparam int ERR_MAX = 3;
   localparam int DUR_MAX = 65535;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        exp_we = 1'b0;
   logic [1:0]  exp_idx = '0;
   logic [31:0] exp_data = '0;
   logic [29:0] addr = '0;
   logic [31:0] data = '0;
   logic        wen = 1'b0;
   logic [1:0]  error_num;
   logic [15:0] duration;
   logic        finish;
   logic        timeout;
   logic [1:0]  curstate;

   int passed = 0;
   int total  = 0;
   string cur_tag = "init";

   int          m_err, m_dur, m_st;
   bit          m_fin, m_to;
   bit          m_seen [DEPTH];
   logic [31:0] m_tbl  [DEPTH];

   store_trace_checker #(
      .ADDR_W(30), .DATA_W(32), .DEPTH(DEPTH), .ANS_BASE(30'h0000_0040),
      .DUR_W(16), .ERR_W(2), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .exp_we(exp_we), .exp_idx(exp_idx), .exp_data(exp_data),
      .addr(addr), .data(data), .wen(wen), .error_num(error_num), .duration(duration),
      .finish(finish), .timeout(timeout), .curstate(curstate)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s/%s observed=%0d expected=%0d", cur_tag, name, obs, expv);
   endtask

   task automatic check_all();
      chk("error_num", 32'(error_num), 32'(m_err));
      chk("duration",  32'(duration),  32'(m_dur));
      chk("finish",    32'(finish),    32'(m_fin));
      chk("timeout",   32'(timeout),   32'(m_to));
      chk("curstate",  32'(curstate),  32'(m_st));
   endtask

   // One rising edge of the specification's rules, applied to the inputs held across it.
   task automatic model_edge(input bit rst, input bit we, input int eidx, input logic [31:0] edat,
                             input int a, input logic [31:0] d, input bit w);
      bit inwin;
      int n_seen;
      if (!rst) begin
         m_err = 0; m_dur = 0; m_st = 0; m_fin = 0; m_to = 0;
         foreach (m_seen[k]) m_seen[k] = 0;
      end else if (m_st != 2) begin
         if (m_dur < DUR_MAX) m_dur++;
         inwin = w && (a >= BASE) && (a < BASE + DEPTH);
         if (inwin) begin
            if (d != m_tbl[a - BASE] && m_err < ERR_MAX) m_err++;
            m_seen[a - BASE] = 1;
         end
         if (we && m_st == 0) m_tbl[eidx] = edat;
         n_seen = 0;
         foreach (m_seen[k]) n_seen += int'(m_seen[k]);
         if (inwin && n_seen == DEPTH) begin
            m_st = 2; m_fin = 1;
         end else if (m_dur == TMO) begin
            m_st = 2; m_fin = 1; m_to = 1;
         end else if (inwin) begin
            m_st = 1;
         end
      end
   endtask

   task automatic step(input bit rst, input bit we, input int eidx, input logic [31:0] edat,
                       input int a, input logic [31:0] d, input bit w);
      rst_n = rst; exp_we = we; exp_idx = 2'(eidx); exp_data = edat;
      addr = 30'(a); data = d; wen = w;
      @(posedge clk);
      model_edge(rst, we, eidx, edat, a, d, w);
      #1;
      check_all();
   endtask

   task automatic do_reset();         step(0, 0, 0, 0, 0, 0, 0);             endtask
   task automatic idle();             step(1, 0, 0, 0, 0, 0, 0);             endtask
   task automatic load(input int i, input int v); step(1, 1, i, v, 0, 0, 0); endtask
   task automatic st(input int off, input int v); step(1, 0, 0, 0, BASE + off, v, 1); endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "watchdog");
   end

   initial begin
      cur_tag = "reset";
      do_reset();
      do_reset();
      chk("rst_err", 32'(error_num), 0);
      chk("rst_state", 32'(curstate), 0);

      cur_tag = "clean";
      load(0, 10); load(1, 20); load(2, 30); load(3, 40);
      idle();
      st(0, 10); st(1, 20); st(2, 30);
      chk("not_done_yet", 32'(finish), 0);
      st(3, 40);
      chk("clean_finish", 32'(finish), 1);
      chk("clean_dur", 32'(duration), 9);
      chk("clean_err", 32'(error_num), 0);
      chk("clean_tmo", 32'(timeout), 0);

      cur_tag = "dup";
      do_reset();
      st(0, 10); st(1, 21);
      chk("dup_err1", 32'(error_num), 1);
      st(2, 30); st(1, 21);
      chk("dup_err2", 32'(error_num), 2);
      chk("dup_open", 32'(finish), 0);
      st(3, 40);
      chk("dup_finish", 32'(finish), 1);

      cur_tag = "window";
      do_reset();
      st(-1, 7); st(4, 7);
      chk("win_idle", 32'(curstate), 0);
      st(0, 10); st(-1, 1); st(1, 20); st(4, 2); st(2, 30); st(3, 40);
      chk("win_err", 32'(error_num), 0);
      chk("win_finish", 32'(finish), 1);

      cur_tag = "timeout";
      do_reset();
      st(0, 10); st(1, 20); st(2, 30);
      for (int n = 0; n < 80 && !finish; n++) idle();
      chk("tmo_finish", 32'(finish), 1);
      chk("tmo_flag", 32'(timeout), 1);
      chk("tmo_dur", 32'(duration), TMO);
      chk("tmo_state", 32'(curstate), 2);
      st(3, 99); st(0, 1); idle();

      cur_tag = "midreset";
      do_reset();
      st(0, 10); st(1, 99);
      do_reset();
      chk("mid_err", 32'(error_num), 0);
      chk("mid_state", 32'(curstate), 0);
      st(0, 10); st(1, 20); st(2, 30); st(3, 40);
      chk("mid_finish", 32'(finish), 1);
      chk("mid_err2", 32'(error_num), 0);

      cur_tag = "saturate";
      do_reset();
      st(0, 10);
      step(1, 1, 1, 77, 0, 0, 0);
      st(1, 20);
      chk("run_load_ignored", 32'(error_num), 0);
      for (int n = 0; n < 6; n++) st(2, 5);
      chk("sat_err", 32'(error_num), 3);
      st(3, 40);
      chk("sat_finish", 32'(finish), 1);

      cur_tag = "same_cycle";
      do_reset();
      step(1, 1, 0, 55, BASE, 10, 1);
      chk("old_entry", 32'(error_num), 0);
      st(0, 55);
      chk("new_entry", 32'(error_num), 0);

      for (int r = 0; r < 10; r++) begin
         cur_tag = $sformatf("rand%0d", r);
         do_reset();
         for (int i = 0; i < DEPTH; i++) load(i, int'($urandom_range(0, 3)));
         for (int n = 0; n < 70; n++) begin
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 3)), 32'($urandom_range(0, 3)),
                 BASE - 2 + int'($urandom_range(0, 7)), 32'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1));
            if (m_st == 2 && $urandom_range(0, 3) == 0) break;
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
